scm_write_arbiter: RTL and testbench
====================================

Name: scm_write_arbiter

Overview:
- Write-side front end for the 1-write-port latch SCM register file.
- Merges N_WRITE independent requesters, each with a valid/ready handshake, onto the single WriteEnable/WriteAddr/WriteData port.
- Each requester has a one-entry holding register; the arbiter is round-robin.
- Exports the address of the write currently being committed into the latch array, so read-side logic can detect read-after-write hazards.

Parameters:
- ADDR_WIDTH, 5, word address width; the SCM holds 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, data word width.
- N_WRITE, 2, number of write requesters; legal range 1..8.

Ports:
- clk  in  1  clock, shared with the SCM.
- rst  in  1  reset; synchronous, active-high.
- wr_valid_i  in  N_WRITE  per-requester request valid.
- wr_ready_o  out  N_WRITE  per-requester ready.
- wr_addr_i  in  N_WRITE x ADDR_WIDTH  per-requester word address.
- wr_data_i  in  N_WRITE x DATA_WIDTH  per-requester write data.
- WriteEnable  out  1  to SCM write enable.
- WriteAddr  out  ADDR_WIDTH  to SCM write address.
- WriteData  out  DATA_WIDTH  to SCM write data.
- grant_o  out  N_WRITE  one-hot; marks the requester issued this cycle.
- pending_o  out  1  a write issued last cycle is committing into the latches this cycle.
- pending_addr_o  out  ADDR_WIDTH  address of the committing write.

Behaviour:
- Holding registers, per port p:
  - State is valid_q[p], addr_q[p], data_q[p].
  - wr_ready_o[p] = !valid_q[p] | grant_o[p], combinational from registered state only.
  - A handshake happens when wr_valid_i[p] & wr_ready_o[p]; addr/data load at that posedge and valid_q[p] is set.
  - Otherwise, if grant_o[p], valid_q[p] clears.
- Arbitration:
  - Candidates are valid_q only; there is no same-cycle bypass from wr_*_i.
  - Minimum latency from handshake edge to WriteEnable=1 is 1 cycle.
  - The search starts at rr_ptr_q and wraps upward modulo N_WRITE; the first valid port wins.
  - grant_o is zero when no valid_q bit is set.
- Outputs to the SCM:
  - WriteEnable = |valid_q.
  - WriteAddr/WriteData = addr_q/data_q of the granted port; all-zero when WriteEnable=0.
  - All three are combinational from registers and stable for the whole cycle; the SCM samples them at the next posedge.
- Round-robin pointer:
  - On a grant to port g, rr_ptr_q <= (g+1) mod N_WRITE.
  - With no grant, the pointer holds.
  - With N_WRITE=1 the pointer is constant 0.
- Fairness and throughput:
  - A continuously valid port waits at most N_WRITE-1 cycles between grants.
  - With a single active port, throughput is one write per cycle, because ready stays high while granted.
- Pending tracking:
  - pending_o <= WriteEnable; pending_addr_o <= WriteAddr when WriteEnable, otherwise it holds.
  - Consumers must not issue a read of pending_addr_o in a cycle where pending_o=1 and expect new data.
- Simultaneous events:
  - Two ports holding the same address are issued in round-robin order; the later-issued write wins in the array.
  - Grant to port p and a new handshake on p in the same cycle: the new request is loaded and valid_q[p] stays 1.
- Reset:
  - Clears valid_q, rr_ptr_q, pending_o, pending_addr_o, addr_q, data_q.
  - Outputs during and after reset: wr_ready_o all 1, WriteEnable 0, grant_o 0, WriteAddr/WriteData 0, pending_o 0.
  - Requests held or in flight when reset is asserted are dropped with no write issued.
  - Handshakes during reset are ignored.

Optional Feature:
- Macro: SCM_WARB_FIXED_PRIO_EN.
- Defined: rr_ptr_q is removed and the search always starts at port 0, so the lowest index wins. Starvation of higher ports is permitted; all other behaviour is unchanged.
- Undefined: round-robin exactly as specified above.

Test Plan:
- Reset check: hold rst for 3 cycles with wr_valid_i all 1 -> WriteEnable=0, wr_ready_o=all 1, pending_o=0. After release, no write from requests presented during reset.
- Single port streaming: N_WRITE=2, port0 sends addr 0..7 with data 0xA0..0xA7 back to back -> WriteEnable high 8 consecutive cycles starting 1 cycle after the first handshake; addresses in order; wr_ready_o[0] never drops.
- Round-robin contention: both ports valid every cycle, port0 addr 3 / data 0x11, port1 addr 9 / data 0x22 -> grant_o alternates 01,10,01,... starting with port0 after reset. With SCM_WARB_FIXED_PRIO_EN, grant_o stays 01 and wr_ready_o[1] stays 0.
- Same-address collision: port0 (addr 5, data 0xAAAA) and port1 (addr 5, data 0xBBBB) accepted together, rr_ptr=0 -> 0xAAAA issued then 0xBBBB; an SCM read of addr 5 afterwards returns 0xBBBB.
- Pending hazard: single write to addr 12 -> pending_o=1 and pending_addr_o=12 exactly in the cycle after WriteEnable, then pending_o=0.
- Reset mid-operation: both holding registers full, assert rst one cycle -> neither write is issued afterwards; first post-reset grant goes to port0.

Source files
------------

// File: rtl/scm_write_arbiter.sv
// Round-robin write-port arbiter for the 1-write-port latch SCM, with per-requester holding registers.
// Define SCM_WARB_FIXED_PRIO_EN to replace round-robin with fixed priority (port 0 highest).
module scm_write_arbiter #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N_WRITE    = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_WRITE-1:0]                   wr_valid_i,
  output logic [N_WRITE-1:0]                   wr_ready_o,
  input  logic [N_WRITE-1:0][ADDR_WIDTH-1:0]   wr_addr_i,
  input  logic [N_WRITE-1:0][DATA_WIDTH-1:0]   wr_data_i,
  output logic                                 WriteEnable,
  output logic [ADDR_WIDTH-1:0]                WriteAddr,
  output logic [DATA_WIDTH-1:0]                WriteData,
  output logic [N_WRITE-1:0]                   grant_o,
  output logic                                 pending_o,
  output logic [ADDR_WIDTH-1:0]                pending_addr_o
);

  localparam int unsigned PTR_W = (N_WRITE > 1) ? $clog2(N_WRITE) : 1;

  logic [N_WRITE-1:0]                 valid_q;
  logic [N_WRITE-1:0][ADDR_WIDTH-1:0] addr_q;
  logic [N_WRITE-1:0][DATA_WIDTH-1:0] data_q;
  logic                               pending_q;
  logic [ADDR_WIDTH-1:0]              pending_addr_q;

  logic [PTR_W-1:0] search_start;
  logic [PTR_W-1:0] grant_idx;
  logic             grant_found;
  int unsigned      scan_idx;

`ifdef SCM_WARB_FIXED_PRIO_EN
  assign search_start = '0;
`else
  logic [PTR_W-1:0] rr_ptr_q;
  logic [PTR_W-1:0] rr_ptr_d;

  // Pointer moves one past the winner so the winner becomes lowest priority next cycle.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_found) begin
      rr_ptr_d = PTR_W'((32'(grant_idx) + 32'd1) % N_WRITE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign search_start = rr_ptr_q;
`endif

  // Search upward from search_start, wrapping modulo N_WRITE; first held request wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    for (int unsigned i = 0; i < N_WRITE; i++) begin
      scan_idx = (32'(search_start) + i) % N_WRITE;
      if (!grant_found && valid_q[PTR_W'(scan_idx)]) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'(scan_idx);
      end
    end
  end

  always_comb begin
    grant_o     = '0;
    WriteAddr   = '0;
    WriteData   = '0;
    if (grant_found) begin
      grant_o[grant_idx] = 1'b1;
      WriteAddr          = addr_q[grant_idx];
      WriteData          = data_q[grant_idx];
    end
  end

  assign WriteEnable    = |valid_q;
  assign wr_ready_o     = ~valid_q | grant_o;
  assign pending_o      = pending_q;
  assign pending_addr_o = pending_addr_q;

  // Holding registers: a new handshake wins over the grant-driven clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      for (int unsigned p = 0; p < N_WRITE; p++) begin
        if (wr_valid_i[p] && wr_ready_o[p]) begin
          valid_q[p] <= 1'b1;
          addr_q[p]  <= wr_addr_i[p];
          data_q[p]  <= wr_data_i[p];
        end else if (grant_o[p]) begin
          valid_q[p] <= 1'b0;
        end
      end
    end
  end

  // Tracks the write being committed into the latches this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q      <= 1'b0;
      pending_addr_q <= '0;
    end else begin
      pending_q <= WriteEnable;
      if (WriteEnable) begin
        pending_addr_q <= WriteAddr;
      end
    end
  end

endmodule

// File: tb/tb_scm_write_arbiter.sv
// Directed self-checking bench for scm_write_arbiter (N_WRITE=2) with a behavioural SCM array.
module tb_scm_write_arbiter;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned NW = 2;

  logic                  clk;
  logic                  rst;
  logic [NW-1:0]         wr_valid;
  logic [NW-1:0]         wr_ready;
  logic [NW-1:0][AW-1:0] wr_addr;
  logic [NW-1:0][DW-1:0] wr_data;
  logic                  we;
  logic [AW-1:0]         waddr;
  logic [DW-1:0]         wdata;
  logic [NW-1:0]         grant;
  logic                  pending;
  logic [AW-1:0]         pending_addr;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int pass_cnt;
  int total_cnt;

  scm_write_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_WRITE(NW)) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_valid_i     (wr_valid),
    .wr_ready_o     (wr_ready),
    .wr_addr_i      (wr_addr),
    .wr_data_i      (wr_data),
    .WriteEnable    (we),
    .WriteAddr      (waddr),
    .WriteData      (wdata),
    .grant_o        (grant),
    .pending_o      (pending),
    .pending_addr_o (pending_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural latch array: samples the write port at each posedge.
  always @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  task automatic apply_reset();
    rst      = 1'b1;
    wr_valid = '0;
    wr_addr  = '0;
    wr_data  = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    wr_valid = 2'b11;
    wr_addr[0] = 5'd1;  wr_data[0] = 32'h1111;
    wr_addr[1] = 5'd2;  wr_data[1] = 32'h2222;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (we !== 1'b0) $display("FAIL reset_we got=%b exp=0", we); else pass_cnt++;
    total_cnt++;
    if (wr_ready !== 2'b11) $display("FAIL reset_ready got=%b exp=11", wr_ready); else pass_cnt++;
    total_cnt++;
    if (pending !== 1'b0) $display("FAIL reset_pending got=%b exp=0", pending); else pass_cnt++;
    total_cnt++;
    if (grant !== 2'b00) $display("FAIL reset_grant got=%b exp=00", grant); else pass_cnt++;
    total_cnt++;
    if (waddr !== 5'd0 || wdata !== 32'd0)
      $display("FAIL reset_wport got=%0d/%h exp=0/0", waddr, wdata);
    else pass_cnt++;
    rst      = 1'b0;
    wr_valid = '0;
    repeat (2) begin
      @(negedge clk);
      total_cnt++;
      if (we !== 1'b0) $display("FAIL reset_no_write got=%b exp=0", we); else pass_cnt++;
    end
  endtask

  task automatic test_streaming();
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        wr_valid   = 2'b01;
        wr_addr[0] = AW'(c);
        wr_data[0] = 32'hA0 + 32'(c);
      end else begin
        wr_valid = '0;
      end
      total_cnt++;
      if (wr_ready[0] !== 1'b1) $display("FAIL stream_ready c=%0d got=%b exp=1", c, wr_ready[0]);
      else pass_cnt++;
      total_cnt++;
      if (we !== (c >= 1 && c <= 8)) $display("FAIL stream_we c=%0d got=%b exp=%b", c, we, (c >= 1 && c <= 8));
      else pass_cnt++;
      if (c >= 1 && c <= 8) begin
        total_cnt++;
        if (waddr !== AW'(c - 1) || wdata !== 32'hA0 + 32'(c - 1) || grant !== 2'b01)
          $display("FAIL stream_word c=%0d got=%0d/%h/%b exp=%0d/%h/01", c, waddr, wdata, grant, c - 1, 32'hA0 + 32'(c - 1));
        else pass_cnt++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_round_robin();
    logic [NW-1:0] exp_g;
    apply_reset();
    wr_valid   = 2'b11;
    wr_addr[0] = 5'd3;  wr_data[0] = 32'h11;
    wr_addr[1] = 5'd9;  wr_data[1] = 32'h22;
    @(negedge clk);
    for (int c = 1; c <= 6; c++) begin
`ifdef SCM_WARB_FIXED_PRIO_EN
      exp_g = 2'b01;
`else
      exp_g = (c % 2 == 1) ? 2'b01 : 2'b10;
`endif
      total_cnt++;
      if (grant !== exp_g) $display("FAIL rr_grant c=%0d got=%b exp=%b", c, grant, exp_g); else pass_cnt++;
      total_cnt++;
      if (wr_ready !== exp_g) $display("FAIL rr_ready c=%0d got=%b exp=%b", c, wr_ready, exp_g); else pass_cnt++;
      total_cnt++;
      if (exp_g == 2'b01 ? (waddr !== 5'd3 || wdata !== 32'h11) : (waddr !== 5'd9 || wdata !== 32'h22))
        $display("FAIL rr_wport c=%0d got=%0d/%h", c, waddr, wdata);
      else pass_cnt++;
      @(negedge clk);
    end
    wr_valid = '0;
  endtask

  task automatic test_collision();
    apply_reset();
    wr_valid   = 2'b11;
    wr_addr[0] = 5'd5;  wr_data[0] = 32'hAAAA;
    wr_addr[1] = 5'd5;  wr_data[1] = 32'hBBBB;
    @(negedge clk);
    wr_valid = '0;
    total_cnt++;
    if (grant !== 2'b01 || wdata !== 32'hAAAA)
      $display("FAIL coll_first got=%b/%h exp=01/0000aaaa", grant, wdata);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (grant !== 2'b10 || wdata !== 32'hBBBB || waddr !== 5'd5)
      $display("FAIL coll_second got=%b/%h exp=10/0000bbbb", grant, wdata);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (we !== 1'b0) $display("FAIL coll_idle got=%b exp=0", we); else pass_cnt++;
    total_cnt++;
    if (mem[5] !== 32'hBBBB) $display("FAIL coll_mem got=%h exp=0000bbbb", mem[5]); else pass_cnt++;
  endtask

  task automatic test_pending();
    apply_reset();
    wr_valid   = 2'b01;
    wr_addr[0] = 5'd12; wr_data[0] = 32'hC0DE;
    @(negedge clk);
    wr_valid = '0;
    total_cnt++;
    if (we !== 1'b1 || waddr !== 5'd12 || pending !== 1'b0)
      $display("FAIL pend_issue got=%b/%0d/%b exp=1/12/0", we, waddr, pending);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (pending !== 1'b1 || pending_addr !== 5'd12 || we !== 1'b0)
      $display("FAIL pend_commit got=%b/%0d/%b exp=1/12/0", pending, pending_addr, we);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (pending !== 1'b0 || pending_addr !== 5'd12)
      $display("FAIL pend_after got=%b/%0d exp=0/12", pending, pending_addr);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    // Advance the pointer to 1 so the post-reset grant proves it was cleared.
    wr_valid   = 2'b01;
    wr_addr[0] = 5'd20; wr_data[0] = 32'h5;
    @(negedge clk);
    wr_valid   = 2'b11;
    wr_addr[0] = 5'd1;  wr_data[0] = 32'h1;
    wr_addr[1] = 5'd2;  wr_data[1] = 32'h2;
    @(negedge clk);
    wr_valid = '0;
    total_cnt++;
    if (valid_full() !== 1'b1) $display("FAIL mid_full got=%b exp=1", valid_full()); else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total_cnt++;
    if (we !== 1'b0 || grant !== 2'b00 || wr_ready !== 2'b11 || pending !== 1'b0)
      $display("FAIL mid_cleared got=%b/%b/%b/%b exp=0/00/11/0", we, grant, wr_ready, pending);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (we !== 1'b0) $display("FAIL mid_no_write got=%b exp=0", we); else pass_cnt++;
    wr_valid   = 2'b11;
    wr_addr[0] = 5'd7;  wr_data[0] = 32'h7;
    wr_addr[1] = 5'd8;  wr_data[1] = 32'h8;
    @(negedge clk);
    wr_valid = '0;
    total_cnt++;
    if (grant !== 2'b01 || waddr !== 5'd7) $display("FAIL mid_first_grant got=%b/%0d exp=01/7", grant, waddr);
    else pass_cnt++;
    repeat (2) @(negedge clk);
  endtask

  // Both holding registers full shows up as neither requester being ready without a grant.
  function automatic logic valid_full();
    return we && ((wr_ready & ~grant) == 2'b00);
  endfunction

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst       = 1'b1;
    wr_valid  = '0;
    wr_addr   = '0;
    wr_data   = '0;
    test_reset();
    test_streaming();
    test_round_robin();
    test_collision();
    test_pending();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
